// File: rtl/hilo_unit_pkg.sv
//------------------------------------------------------------------------------
// hilo_unit_pkg : shared pipeline types for the HI/LO shadow register unit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package hilo_unit_pkg;

    localparam int W_DATA  = 32;
    localparam int N_SLOTS = 2;

    // One in-flight HI/LO write record; each half carries its own valid bit
    typedef struct packed {
        logic              hi_valid;
        logic [W_DATA-1:0] hi_data;
        logic              lo_valid;
        logic [W_DATA-1:0] lo_data;
    } slot_t;

endpackage

`default_nettype wire

// File: rtl/hilo_unit_if.sv
//------------------------------------------------------------------------------
// hilo_unit_if : EX-stage write/read bundle between the pipeline and hilo_unit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface hilo_unit_if;
    import hilo_unit_pkg::*;

    logic              stall;
    logic              flush;
    logic              md_busy;
    logic              hi_write;
    logic [W_DATA-1:0] hi_write_data;
    logic              lo_write;
    logic [W_DATA-1:0] lo_write_data;
    logic              mf_req;
    logic [W_DATA-1:0] hi;
    logic [W_DATA-1:0] lo;
    logic [W_DATA-1:0] hi_arch;
    logic [W_DATA-1:0] lo_arch;
    logic              mf_stall;

    modport master (
        output stall, flush, md_busy, hi_write, hi_write_data,
               lo_write, lo_write_data, mf_req,
        input  hi, lo, hi_arch, lo_arch, mf_stall
    );

    modport slave (
        input  stall, flush, md_busy, hi_write, hi_write_data,
               lo_write, lo_write_data, mf_req,
        output hi, lo, hi_arch, lo_arch, mf_stall
    );

endinterface

`default_nettype wire

// File: rtl/hilo_unit.sv
//------------------------------------------------------------------------------
// hilo_unit : HI/LO registers with MEM/WB shadow slots and newest-first forwarding
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hilo_unit
    import hilo_unit_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst,
    hilo_unit_if.slave bus
);

    // shadow[0] is S1 (MEM), shadow[N_SLOTS-1] is S2 (WB)
    slot_t             shadow [N_SLOTS];
    logic [W_DATA-1:0] arch_hi;
    logic [W_DATA-1:0] arch_lo;
    logic [W_DATA-1:0] fwd_hi;
    logic [W_DATA-1:0] fwd_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                shadow[i] <= '0;
            end
            arch_hi <= '0;
            arch_lo <= '0;
        end else if (bus.flush) begin
            // Only the valid bits are dropped; stale data is never selected
            for (int i = 0; i < N_SLOTS; i++) begin
                shadow[i].hi_valid <= 1'b0;
                shadow[i].lo_valid <= 1'b0;
            end
        end else if (!bus.stall) begin
            if (shadow[N_SLOTS-1].hi_valid) begin
                arch_hi <= shadow[N_SLOTS-1].hi_data;
            end
            if (shadow[N_SLOTS-1].lo_valid) begin
                arch_lo <= shadow[N_SLOTS-1].lo_data;
            end
            for (int i = N_SLOTS - 1; i > 0; i--) begin
                shadow[i] <= shadow[i-1];
            end
            shadow[0] <= '{hi_valid: bus.hi_write,
                           hi_data:  bus.hi_write_data,
                           lo_valid: bus.lo_write,
                           lo_data:  bus.lo_write_data};
        end
    end

    // Oldest source first so that younger valid slots overwrite the result
    always_comb begin
        fwd_hi = arch_hi;
        fwd_lo = arch_lo;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (shadow[i].hi_valid) begin
                fwd_hi = shadow[i].hi_data;
            end
            if (shadow[i].lo_valid) begin
                fwd_lo = shadow[i].lo_data;
            end
        end
    end

    assign bus.hi       = fwd_hi;
    assign bus.lo       = fwd_lo;
    assign bus.hi_arch  = arch_hi;
    assign bus.lo_arch  = arch_lo;
    assign bus.mf_stall = bus.mf_req & bus.md_busy;

endmodule

`default_nettype wire
